// File: rtl/rv_pkg.sv
// rv_pkg: shared ready/valid buffer state encoding for the FIFO library
// Contents:
//   rv_state_e - occupancy state of a two-entry skid buffer (EMPTY/BUSY/FULL)
package rv_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } rv_state_e;
endpackage

// File: rtl/rv_skid_buffer.sv
// rv_skid_buffer: two-entry ready/valid skid buffer with fully registered outputs
// Ports:
//   clk     - clock, all state updates on rising edge
//   reset_n - synchronous active-low reset
//   s_valid - upstream valid
//   s_data  - upstream payload
//   s_ready - buffer can accept a beat (flop)
//   m_valid - downstream valid (flop)
//   m_data  - downstream payload, the OUT register
//   m_ready - downstream accepts a beat
module rv_skid_buffer
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);
    rv_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
    logic                  s_ready_q, m_valid_q;
    logic                  up, dn;

    assign up      = s_valid && s_ready_q;
    assign dn      = m_valid_q && m_ready;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                out_d   = up ? s_data : out_q;
                state_d = up ? BUSY : EMPTY;
            end
            BUSY: begin
                // simultaneous in/out refreshes OUT; in-only spills into SKID
                out_d   = (up && dn) ? s_data : out_q;
                skid_d  = (up && !dn) ? s_data : skid_q;
                state_d = (up && !dn) ? FULL : (!up && dn) ? EMPTY : BUSY;
            end
            FULL: begin
                out_d   = dn ? skid_q : out_q;
                state_d = dn ? BUSY : FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // handshake outputs are registered from the next state so no input reaches an output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != FULL);
            m_valid_q <= (state_d != EMPTY);
        end
    end
endmodule

// File: tb/tb_rv_skid_buffer.sv
// tb_rv_skid_buffer: directed and randomized self-checking bench for rv_skid_buffer
module tb_rv_skid_buffer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    int         total = 0;
    int         bad = 0;

    rv_skid_buffer #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d, held;
        logic       up, dn, hold;
        int         pushed, cyc;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        step();
        step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        reset_n = 1'b1;
        step();
        chk("rel_s_ready", s_ready, 1);
        chk("rel_m_valid", m_valid, 0);

        // single beat latency
        s_valid = 1'b1;
        s_data  = 8'h11;
        m_ready = 1'b1;
        step();
        chk("lat_m_valid", m_valid, 1);
        chk("lat_m_data", m_data, 8'h11);
        s_valid = 1'b0;
        step();
        chk("lat_drain", m_valid, 0);

        // full-rate stream
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            step();
            chk("str_m_valid", m_valid, 1);
            chk("str_m_data", m_data, i);
            chk("str_s_ready", s_ready, 1);
        end
        s_valid = 1'b0;
        step();
        chk("str_drain", m_valid, 0);

        // backpressure fills SKID
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA0;
        step();
        chk("bp_busy_s_ready", s_ready, 1);
        chk("bp_busy_data", m_data, 8'hA0);
        s_data = 8'hA1;
        step();
        chk("bp_full_s_ready", s_ready, 0);
        chk("bp_full_data", m_data, 8'hA0);
        s_data = 8'hA2;
        step();
        chk("bp_ignored_s_ready", s_ready, 0);
        chk("bp_ignored_data", m_data, 8'hA0);
        chk("bp_ignored_valid", m_valid, 1);
        m_ready = 1'b1;
        step();
        chk("bp_out1", m_data, 8'hA1);
        chk("bp_out1_s_ready", s_ready, 1);
        step();
        chk("bp_out2", m_data, 8'hA2);
        chk("bp_out2_valid", m_valid, 1);
        s_valid = 1'b0;
        step();
        chk("bp_drain", m_valid, 0);

        // reset while FULL discards both beats
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hB0;
        step();
        s_data = 8'hB1;
        step();
        chk("rf_full", s_ready, 0);
        s_valid = 1'b0;
        reset_n = 1'b0;
        step();
        chk("rf_m_valid", m_valid, 0);
        chk("rf_s_ready", s_ready, 0);
        chk("rf_m_data", m_data, 0);
        reset_n = 1'b1;
        m_ready = 1'b1;
        step();
        chk("rf_s_ready_back", s_ready, 1);
        chk("rf_no_ghost", m_valid, 0);
        step();
        chk("rf_no_ghost2", m_valid, 0);

        // randomized traffic against a queue model
        pushed = 0;
        cyc = 0;
        while (pushed < 10000 && cyc < 60000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            up   = s_valid && s_ready;
            dn   = m_valid && m_ready;
            hold = m_valid && !m_ready;
            held = m_data;
            if (dn) begin
                if (q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    exp_d = q.pop_front();
                    chk("sb_data", m_data, exp_d);
                end
            end
            if (up) begin
                q.push_back(s_data);
                pushed++;
            end
            step();
            cyc++;
            chk("sb_m_valid", m_valid, q.size() > 0);
            chk("sb_s_ready", s_ready, q.size() < 2);
            if (hold) chk("sb_hold", m_data, held);
        end
        chk("sb_budget", pushed >= 10000, 1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3 && q.size() > 0; i++) begin
            #1;
            if (m_valid) begin
                exp_d = q.pop_front();
                chk("sb_tail", m_data, exp_d);
            end
            step();
        end
        chk("sb_empty", q.size(), 0);
        chk("sb_final_valid", m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
